ps2_key_fifo: RTL
=================

Name: ps2_key_fifo

Overview:
- Buffers PS/2 key events from the HPS `ps2_key` bus so the Z80 does not miss keys that arrive faster than it polls.
- Sits upstream of the system CPU data mux and replaces direct reads of the raw `ps2_key` window.
- Detects the bit-10 toggle, queues {pressed, extended, code} into a small FIFO, and exposes a 4-byte memory-mapped register window.
- A pop is a CPU write, so Z80 multi-cycle reads never have side effects.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16). Legal range 2..7.

Ports:
- clk_24  in  1  system clock, 24 MHz
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event
- cs  in  1  chip select, from CPU address decode
- addr  in  2  register offset, cpu_addr[1:0]
- wr_n  in  1  CPU write strobe, active low
- dout  out  8  register read data, combinational
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries
- overflow  out  1  sticky flag: an event was dropped
- count  out  DEPTH_LOG2+1  current number of entries

Behaviour:
- Reset (reset_n low, async): read/write pointers 0, count 0, empty 1, full 0, overflow 0, armed 0, toggle shadow 0.
  - The first clk_24 edge after release loads the toggle shadow from ps2_key[10] and sets armed=1. No push on that edge.
- Event detect: when armed and ps2_key[10] != shadow, push {ps2_key[9:0]} (10 bits) and update the shadow.
  - The entry is visible at the head on the next cycle: empty falls one cycle after the toggle edge.
- Write decode: wr_act = cs & ~wr_n. An action fires only on the first cycle of wr_act (rising-edge detect, registered previous value).
  - The edge-detect register resets to 0.
  - offset 0 write: pop the head entry. Ignored if empty.
  - offset 1 write: clear overflow.
  - offset 2 write: flush. Pointers and count go to 0, overflow cleared. The shadow is kept.
  - offset 3 write: no effect.
- Read mux (dout), valid whenever cs is high; dout = 0x00 when cs is low:
  - offset 0: head scancode, or 0x00 if empty.
  - offset 1: {empty, full, overflow, head_pressed, head_extended, 3'b000}. Head bits are 0 if empty.
  - offset 2: count, zero-extended to 8 bits.
  - offset 3: 0x00.
- Simultaneous push and pop on the same cycle:
  - Both take effect; count unchanged.
  - Applies even when full: no overflow, the new entry is accepted.
  - If empty, the pop is ignored and the push proceeds.
- Push when full and no pop: the event is dropped, overflow set to 1 (sticky), the shadow still updates.
- Flush and push on the same cycle: the flush wins and the event is dropped; overflow is not set.
- Pointers wrap modulo 2**DEPTH_LOG2.
- count = write pointer minus read pointer, using DEPTH_LOG2+1 bit pointers. full when count == 2**DEPTH_LOG2.
- Storage: register array or inferred RAM with combinational head read. The head must be readable in the same cycle as the address.
- Reset asserted mid-operation: all state clears immediately. Pending entries are lost.

Optional Feature:
- Macro PS2_KEY_FIFO_REPEAT_FILTER_EN.
- Defined:
  - A last-pushed register (10 bits plus valid, reset invalid) records each accepted event.
  - A detected event identical to the last pushed event is discarded: no push, no overflow, shadow updated. This suppresses typematic repeats.
  - Flush invalidates the register.
- Undefined: every toggle is pushed. No extra registers are built.

Test Plan:
- Reset release with ps2_key[10]=1 held -> no push; count=0, empty=1, offset 1 reads 0x80.
- Toggle with ps2_key[9:0]=0x31C (pressed, extended, code 0x1C) -> offset 0 reads 0x1C, offset 1 reads 0x18, count=1. Write offset 0 -> empty=1, offset 0 reads 0x00.
- 17 toggles with codes 0x01..0x11, DEPTH_LOG2=4 -> full=1, overflow=1, count=16.
  - 16 pops return 0x01..0x10 in order.
  - Write offset 1 -> overflow=0.
- Full FIFO, toggle coincident with the first cycle of an offset 0 write -> count stays 16, overflow stays 0, last popped data is the new code.
- wr_n held low for 4 cycles on offset 0 with 3 entries -> exactly one pop; count=2. Flush write -> count=0, overflow=0.
- With PS2_KEY_FIFO_REPEAT_FILTER_EN: three identical press events of 0x21C -> count=1.
  - A release 0x01C follows -> count=2.
  - Without the macro the same stimulus gives count=4.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: buffers PS/2 key events from the HPS ps2_key bus for Z80 polling.
// A toggle on ps2_key[10] queues {pressed, extended, code}. A 4-byte register
// window exposes the head, status and count. A CPU write pops, clears or flushes,
// so multi-cycle reads never have side effects.
// Optional: define PS2_KEY_FIFO_REPEAT_FILTER_EN to drop events identical to the
// last accepted one (typematic repeat suppression).
module ps2_key_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk_24,
  input  logic                reset_n,
  input  logic [10:0]         ps2_key,
  input  logic                cs,
  input  logic [1:0]          addr,
  input  logic                wr_n,
  output logic [7:0]          dout,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = 1;

  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]          mem_q [Depth];
  logic                armed_q, shadow_q, wr_prev_q, overflow_q;

  logic       wr_act, wr_fire;
  logic       pop_cmd, clr_cmd, flush_cmd;
  logic       evt, repeat_evt, push_req, do_push, do_pop, drop_full;
  logic [9:0] head;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  // count never exceeds Depth, so its MSB alone marks the full state
  assign full     = count[DEPTH_LOG2];
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Only the first cycle of a CPU write acts, so a held wr_n pops once
  assign wr_act    = cs & ~wr_n;
  assign wr_fire   = wr_act & ~wr_prev_q;
  assign pop_cmd   = wr_fire & (addr == 2'd0);
  assign clr_cmd   = wr_fire & (addr == 2'd1);
  assign flush_cmd = wr_fire & (addr == 2'd2);

  assign evt       = armed_q & (ps2_key[10] != shadow_q);
  // Flush beats a coincident event; the event is lost without flagging overflow
  assign push_req  = evt & ~repeat_evt & ~flush_cmd;
  assign do_pop    = pop_cmd & ~empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push
  assign do_push   = push_req & (~full | do_pop);
  assign drop_full = push_req & full & ~do_pop;

`ifdef PS2_KEY_FIFO_REPEAT_FILTER_EN
  logic [9:0] last_q;
  logic       last_vld_q;

  assign repeat_evt = last_vld_q & (last_q == ps2_key[9:0]);

  // Remember the last accepted event; flush forgets it
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (flush_cmd) begin
      last_vld_q <= 1'b0;
    end else if (do_push) begin
      last_q     <= ps2_key[9:0];
      last_vld_q <= 1'b1;
    end
  end
`else
  assign repeat_evt = 1'b0;
`endif

  // Toggle shadow, arming and write edge detect; first edge after reset only arms
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= 1'b0;
      shadow_q  <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      armed_q   <= 1'b1;
      shadow_q  <= ps2_key[10];
      wr_prev_q <= wr_act;
    end
  end

  // Read/write pointers; flush returns both to zero
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_cmd) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves it set
  always_ff @(posedge clk_24 or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (flush_cmd) begin
      overflow_q <= 1'b0;
    end else if (drop_full) begin
      overflow_q <= 1'b1;
    end else if (clr_cmd) begin
      overflow_q <= 1'b0;
    end
  end

  // Entry storage, no reset needed; contents are qualified by the pointers
  always_ff @(posedge clk_24) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= ps2_key[9:0];
  end

  // Register window read mux
  always_comb begin
    dout = 8'h00;
    if (cs) begin
      case (addr)
        2'd0:    dout = empty ? 8'h00 : head[7:0];
        2'd1:    dout = {empty, full, overflow_q, ~empty & head[9], ~empty & head[8], 3'b000};
        2'd2:    dout = 8'(count);
        default: dout = 8'h00;
      endcase
    end
  end

endmodule
